// File: rtl/program_loader.sv
// program_loader: byte-stream loader that fills program memory and gates CPU reset.
//   clk        rising-edge clock
//   rst        asynchronous active-low reset
//   load_start one-cycle pulse that begins or restarts a frame load
//   in_valid   stream byte valid
//   in_data    stream byte: length header, then payload, then checksum
//   in_ready   loader accepts a byte this cycle (HDR, DATA, CSUM)
//   pm_wr_en   program-memory write strobe, one cycle after each payload accept
//   pm_addr    program-memory write address, counting up from 0
//   pm_data    program-memory write data
//   cpu_hold   1 keeps the CPU in reset (everywhere except DONE)
//   busy       a frame load is in progress
//   done       the last frame loaded with a good checksum
//   err_code   00 none, 01 bad length, 10 checksum mismatch
module program_loader #(
    parameter int DATA_WIDTH = 8,
    parameter int ADD_WIDTH  = 7,
    parameter int DEPTH      = 128
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load_start,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  in_ready,
    output logic                  pm_wr_en,
    output logic [ADD_WIDTH-1:0]  pm_addr,
    output logic [DATA_WIDTH-1:0] pm_data,
    output logic                  cpu_hold,
    output logic                  busy,
    output logic                  done,
    output logic [1:0]            err_code
);
    localparam int CW = $clog2(DEPTH + 1);

    typedef enum logic [2:0] {IDLE, HDR, DATA, CSUM, DONE, ERR} state_t;

    state_t                state, nxt;
    logic [CW-1:0]         len, cnt;
    logic [ADD_WIDTH-1:0]  addr;
    logic [DATA_WIDTH-1:0] sum;
    logic                  acc, wr, bad_len;

    // load_start wins over a simultaneous byte, which is then discarded
    assign acc     = in_valid & in_ready & ~load_start;
    assign wr      = acc & (state == DATA);
    assign bad_len = (in_data == '0) || (32'(in_data) > DEPTH);

    always_comb begin
        nxt = state;
        if (load_start) nxt = HDR;
        else if (acc) begin
            case (state)
                HDR:     nxt = bad_len ? ERR : DATA;
                DATA:    nxt = (cnt == len - CW'(1)) ? CSUM : DATA;
                CSUM:    nxt = (in_data == sum) ? DONE : ERR;
                default: nxt = state;
            endcase
        end
    end

    // Moore outputs are registered from the next state so they change with it
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            len      <= '0;
            cnt      <= '0;
            addr     <= '0;
            sum      <= '0;
            pm_wr_en <= 1'b0;
            pm_addr  <= '0;
            pm_data  <= '0;
            in_ready <= 1'b0;
            cpu_hold <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b0;
            err_code <= 2'b00;
        end else begin
            state    <= nxt;
            in_ready <= nxt inside {HDR, DATA, CSUM};
            busy     <= nxt inside {HDR, DATA, CSUM};
            cpu_hold <= nxt != DONE;
            done     <= nxt == DONE;
            pm_wr_en <= wr;
            if (wr) begin
                pm_addr <= addr;
                pm_data <= in_data;
                addr    <= addr + ADD_WIDTH'(1);
                sum     <= sum + in_data;
                cnt     <= cnt + CW'(1);
            end
            if (load_start) begin
                cnt      <= '0;
                addr     <= '0;
                sum      <= '0;
                err_code <= 2'b00;
            end else if (acc && state == HDR) begin
                if (bad_len) err_code <= 2'b01;
                else len <= CW'(in_data);
            end else if (acc && state == CSUM && in_data != sum) begin
                err_code <= 2'b10;
            end
        end
    end
endmodule

// File: tb/tb_program_loader.sv
// tb_program_loader: scoreboard bench for program_loader.
module tb_program_loader;
    logic       clk = 1'b0;
    logic       rst;
    logic       load_start;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic       pm_wr_en;
    logic [6:0] pm_addr;
    logic [7:0] pm_data;
    logic       cpu_hold;
    logic       busy;
    logic       done;
    logic [1:0] err_code;

    int          tests = 0;
    int          fails = 0;
    logic [14:0] sb[$];
    logic [6:0]  exp_addr;

    always #5 clk = ~clk;

    program_loader #(.DATA_WIDTH(8), .ADD_WIDTH(7), .DEPTH(128)) dut (
        .clk(clk), .rst(rst), .load_start(load_start), .in_valid(in_valid),
        .in_data(in_data), .in_ready(in_ready), .pm_wr_en(pm_wr_en),
        .pm_addr(pm_addr), .pm_data(pm_data), .cpu_hold(cpu_hold),
        .busy(busy), .done(done), .err_code(err_code)
    );

    // One clock: drive at the negedge, let the posedge act, then compare any
    // write pulse against the scoreboard at the following negedge.
    task automatic step(input bit v, input logic [7:0] d, input bit ls, input bit pl);
        logic [14:0] e;
        in_valid   = v;
        in_data    = d;
        load_start = ls;
        if (ls) exp_addr = 7'd0;
        if (v && pl && !ls) begin
            sb.push_back({exp_addr, d});
            exp_addr = exp_addr + 7'd1;
        end
        @(posedge clk);
        @(negedge clk);
        in_valid   = 1'b0;
        load_start = 1'b0;
        if (pm_wr_en || sb.size() != 0) begin
            tests++;
            if (!pm_wr_en) begin
                e = sb.pop_front();
                fails++;
                $display("FAIL wr_missing: got no write, expected %h@%h", e[7:0], e[14:8]);
            end else if (sb.size() == 0) begin
                fails++;
                $display("FAIL wr_unexpected: got %h@%h, expected no write", pm_data, pm_addr);
            end else begin
                e = sb.pop_front();
                if ({pm_addr, pm_data} !== e) begin
                    fails++;
                    $display("FAIL wr_data: got %h@%h, expected %h@%h", pm_data, pm_addr, e[7:0], e[14:8]);
                end
            end
        end
    endtask

    task automatic test_reset();
        step(0, 8'h00, 1, 0);
        step(1, 8'h04, 0, 0);
        step(1, 8'h55, 0, 1);
        rst = 1'b0;
        step(1, 8'h66, 0, 0);
        step(1, 8'h77, 0, 0);
        tests++;
        if ({pm_wr_en, pm_addr, pm_data, in_ready} !== 17'd0) begin
            fails++;
            $display("FAIL reset_pm: got wr=%b addr=%h data=%h rdy=%b, expected all 0", pm_wr_en, pm_addr, pm_data, in_ready);
        end
        tests++;
        if ({cpu_hold, busy, done, err_code} !== 5'b10000) begin
            fails++;
            $display("FAIL reset_status: got %b, expected 10000", {cpu_hold, busy, done, err_code});
        end
        rst = 1'b1;
        for (int i = 0; i < 3; i++) step(1, 8'($urandom), 0, 0);
        tests++;
        if ({in_ready, busy, cpu_hold, done} !== 4'b0010) begin
            fails++;
            $display("FAIL idle_no_accept: got %b, expected 0010", {in_ready, busy, cpu_hold, done});
        end
    endtask

    task automatic test_good_frame();
        step(0, 8'h00, 1, 0);
        tests++;
        if ({busy, in_ready, done, cpu_hold} !== 4'b1101) begin
            fails++;
            $display("FAIL hdr_state: got %b, expected 1101", {busy, in_ready, done, cpu_hold});
        end
        step(1, 8'h04, 0, 0);
        step(1, 8'h13, 0, 1);
        step(1, 8'h05, 0, 1);
        step(1, 8'h00, 0, 1);
        step(1, 8'h00, 0, 1);
        step(1, 8'h18, 0, 0);
        step(0, 8'h00, 0, 0);
        tests++;
        if ({done, cpu_hold, busy, in_ready, err_code} !== 6'b100000) begin
            fails++;
            $display("FAIL good_done: got %b, expected 100000", {done, cpu_hold, busy, in_ready, err_code});
        end
    endtask

    task automatic test_bad_length();
        step(0, 8'h00, 1, 0);
        step(1, 8'h00, 0, 0);
        tests++;
        if ({err_code, cpu_hold, done, busy} !== 5'b01100) begin
            fails++;
            $display("FAIL len_zero: got %b, expected 01100", {err_code, cpu_hold, done, busy});
        end
        step(0, 8'h00, 1, 0);
        tests++;
        if (err_code !== 2'b00) begin
            fails++;
            $display("FAIL start_clears_err: got %b, expected 00", err_code);
        end
        step(1, 8'h81, 0, 0);
        step(1, 8'h12, 0, 0);
        tests++;
        if ({err_code, cpu_hold, done, busy} !== 5'b01100) begin
            fails++;
            $display("FAIL len_over: got %b, expected 01100", {err_code, cpu_hold, done, busy});
        end
    endtask

    task automatic test_csum_err();
        step(0, 8'h00, 1, 0);
        step(1, 8'h02, 0, 0);
        step(1, 8'hFF, 0, 1);
        step(1, 8'h02, 0, 1);
        step(1, 8'h00, 0, 0);
        tests++;
        if ({err_code, cpu_hold, done, busy} !== 5'b10100) begin
            fails++;
            $display("FAIL csum_err: got %b, expected 10100", {err_code, cpu_hold, done, busy});
        end
    endtask

    task automatic test_stalls_full();
        step(0, 8'h00, 1, 0);
        step(1, 8'h80, 0, 0);
        for (int i = 0; i < 128; i++) begin
            step(1, 8'(i), 0, 1);
            step(0, 8'($urandom), 0, 0);
        end
        tests++;
        if ({in_ready, busy, pm_addr} !== {2'b11, 7'd127}) begin
            fails++;
            $display("FAIL full_csum_wait: got rdy=%b busy=%b addr=%h, expected 1 1 7f", in_ready, busy, pm_addr);
        end
        step(1, 8'hC0, 0, 0);
        tests++;
        if ({done, cpu_hold, err_code} !== 4'b1000) begin
            fails++;
            $display("FAIL full_done: got %b, expected 1000", {done, cpu_hold, err_code});
        end
    endtask

    task automatic test_abort();
        step(0, 8'h00, 1, 0);
        step(1, 8'h04, 0, 0);
        step(1, 8'h11, 0, 1);
        step(1, 8'h22, 0, 1);
        step(1, 8'h33, 1, 0);
        step(1, 8'h01, 0, 0);
        step(1, 8'hAA, 0, 1);
        step(1, 8'hAA, 0, 0);
        tests++;
        if ({done, cpu_hold, busy, err_code} !== 5'b10000) begin
            fails++;
            $display("FAIL abort_done: got %b, expected 10000", {done, cpu_hold, busy, err_code});
        end
    endtask

    task automatic test_back_to_back();
        step(0, 8'h00, 1, 0);
        step(1, 8'h03, 0, 0);
        step(1, 8'hA5, 0, 1);
        step(1, 8'h5A, 0, 1);
        step(1, 8'h01, 0, 1);
        step(1, 8'h00, 0, 0);
        tests++;
        if ({done, err_code} !== 3'b100) begin
            fails++;
            $display("FAIL b2b_done: got %b, expected 100", {done, err_code});
        end
    endtask

    initial begin
        rst        = 1'b0;
        load_start = 1'b0;
        in_valid   = 1'b0;
        in_data    = 8'h00;
        exp_addr   = 7'd0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        test_reset();
        test_good_frame();
        test_bad_length();
        test_csum_err();
        test_stalls_full();
        test_abort();
        test_back_to_back();
        tests++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL sb_drain: got %0d pending writes, expected 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/program_loader.md
Name: program_loader

Overview:
Byte-stream program loader that fills the CPU's program memory.
- Accepts a framed byte stream (length header, payload, checksum) over a valid/ready handshake.
- Drives the program-memory write port (`pmWrEn`, `pm_addr`, `instructionIn` of the CPU top) with consecutive addresses from 0.
- Holds the CPU in reset until a frame loads with a correct checksum.

Parameters:
- `DATA_WIDTH`, 8, width of each program-memory byte and stream byte.
- `ADD_WIDTH`, 7, program-memory address width.
- `DEPTH`, 128, maximum payload bytes; must equal 2**ADD_WIDTH.

Ports:
- `clk`  input  1  clock; all state changes on rising edge.
- `rst`  input  1  asynchronous, active-low reset.
- `load_start`  input  1  one-cycle pulse; begins (or restarts) a frame load.
- `in_valid`  input  1  stream byte valid.
- `in_data`  input  DATA_WIDTH  stream byte.
- `in_ready`  output  1  loader can accept a byte this cycle.
- `pm_wr_en`  output  1  program-memory write strobe.
- `pm_addr`  output  ADD_WIDTH  program-memory write address.
- `pm_data`  output  DATA_WIDTH  program-memory write data.
- `cpu_hold`  output  1  1 = keep CPU in reset.
- `busy`  output  1  a frame load is in progress.
- `done`  output  1  last frame loaded with a good checksum.
- `err_code`  output  2  00 none, 01 bad length, 10 checksum mismatch.

Behaviour:
- States: IDLE, HDR, DATA, CSUM, DONE, ERR.
- Reset (`rst`=0, asynchronous) forces state IDLE and these output values:
  - `pm_wr_en`=0, `pm_addr`=0, `pm_data`=0, `in_ready`=0.
  - `cpu_hold`=1, `busy`=0, `done`=0, `err_code`=00.
  - Any pending write is dropped.
- Handshake: a byte is accepted on a rising edge with `in_valid` & `in_ready`. `in_ready` is a Moore output: 1 in HDR, DATA and CSUM, 0 elsewhere. `in_data` is ignored when not accepted.
- `load_start` in any state except reset:
  - next state HDR; byte counter, address counter and running sum cleared.
  - `done` and `err_code` cleared.
  - A load already in progress is aborted; its partially written bytes are not erased.
- HDR: accepted byte is length N.
  - N==0 or N>DEPTH -> ERR with `err_code`=01.
  - Otherwise store N -> DATA.
- DATA: each accepted byte b is added to the running sum (8-bit, mod 256).
  - Next cycle: `pm_wr_en`=1 for exactly one cycle, `pm_data`=b, `pm_addr`=current address; address then increments.
  - Write latency is 1 cycle after accept. Back-to-back accepts produce back-to-back writes (one per cycle, no bubbles).
  - After the Nth byte is accepted -> CSUM. The write of byte N occurs during the first CSUM cycle.
- Address arithmetic: ADD_WIDTH-bit counter from 0. With N<=DEPTH the last address is N-1 and the counter never wraps within a frame.
- CSUM: accepted byte c.
  - c == running sum -> DONE.
  - else -> ERR with `err_code`=10.
- DONE: `cpu_hold`=0, `done`=1, `busy`=0, stays until `load_start` or reset.
- ERR: `cpu_hold`=1, `done`=0, stays until `load_start` or reset.
- `busy`=1 in HDR, DATA, CSUM.
- `cpu_hold`=1 in every state except DONE.
- `pm_wr_en` is 0 in all cycles other than the single cycle following a DATA accept. `pm_addr` and `pm_data` hold their last values when `pm_wr_en`=0.
- `load_start` coinciding with a byte accept: `load_start` wins and the byte is discarded. The write pulse for a byte accepted in the previous cycle still completes.
- `in_valid` low (stall) in any loading state: state and counters hold, no write.

Test Plan:
- Reset then idle: `rst` low for 2 cycles mid-stream -> all outputs at reset values, `cpu_hold`=1, `in_ready`=0; bytes offered with `load_start` absent are never accepted.
- Good frame, continuous valid: `load_start`, then bytes 0x04, 0x13, 0x05, 0x00, 0x00, checksum 0x18 -> four `pm_wr_en` pulses on consecutive cycles at addresses 0..3 with data 0x13, 0x05, 0x00, 0x00; then `done`=1, `cpu_hold`=0, `err_code`=00.
- Bad length: headers 0x00, then (after a new `load_start`) 0x81 -> ERR, `err_code`=01, zero writes, `cpu_hold`=1.
- Checksum error: frame 0x02, 0xFF, 0x02, checksum 0x00 -> writes 0xFF@0 and 0x02@1, then ERR with `err_code`=10 (expected sum 0x01), `cpu_hold` stays 1.
- Stalls and full depth: N=128 (0x80), bytes 0x00..0x7F with `in_valid` toggled every other cycle, checksum 0xC0 -> 128 writes at addresses 0..127 only on accept+1 cycles, `done`=1.
- Abort: `load_start` re-pulsed after 2 of 4 payload bytes, then a good 1-byte frame 0x01, 0xAA, 0xAA -> write 0xAA@0, `done`=1, no spurious `err_code`.
